// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: unsigned/signed MUL and DIV over 8/16/32-bit operands,
// one shift-add or restoring shift-subtract step per cycle.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] opnd0_r,
  input  logic [XLEN-1:0] opnd1_r,
  input  logic [XLEN-1:0] opnd2_r,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_lo,
  output logic [XLEN-1:0] result_hi,
  output logic            cf_of,
  output logic            div_fault,
  output logic            busy
);
  localparam int unsigned DW = 2 * XLEN;
  localparam int unsigned CW = 6;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
  state_t state, next_state;
  logic in_ready_d, busy_d, out_valid_d;

  logic [1:0]      op_q;
  logic [CW-1:0]   n_q, cnt_q;
  logic [XLEN-1:0] opa_q, opb_raw_q, opc_q;
  logic [XLEN-1:0] opb_q, mq_q, rem_q;
  logic [DW-1:0]   acc_q;
  logic            res_neg_q, rem_neg_q;

  function automatic logic [CW-1:0] eff_n(input logic [1:0] s);
    logic [CW-1:0] n;
    case (s)
      2'b00:   n = CW'(8);
      2'b01:   n = CW'(16);
      default: n = CW'(32);
    endcase
    if (n > CW'(XLEN)) n = CW'(XLEN);
    return n;
  endfunction

  logic is_div, is_sgn;
  assign is_div = op_q[1];
  assign is_sgn = op_q[0];

  // Operand masks for the effective width; top_n is the sign-bit position.
  logic [XLEN-1:0] mask_n, top_n;
  logic [DW-1:0]   mask_2n;
  always_comb begin
    mask_n  = '0;
    mask_2n = '0;
    for (int i = 0; i < XLEN; i++) mask_n[i] = (i < int'(n_q));
    for (int i = 0; i < int'(DW); i++) mask_2n[i] = (i < 2 * int'(n_q));
  end
  assign top_n = mask_n & ~(mask_n >> 1);

  // Magnitudes and the early divide-error check used in PREP.
  logic [XLEN-1:0] a_m, b_m, c_m, a_mag, b_mag, hi_mag, lo_mag;
  logic            a_neg, b_neg, c_neg, prep_fault;
  logic [DW-1:0]   dvd_raw, dvd_mag;
  logic [CW-1:0]   shamt;
  always_comb begin
    a_m        = opa_q & mask_n;
    b_m        = opb_raw_q & mask_n;
    c_m        = opc_q & mask_n;
    a_neg      = is_sgn & (|(a_m & top_n));
    b_neg      = is_sgn & (|(b_m & top_n));
    c_neg      = is_sgn & (|(c_m & top_n));
    a_mag      = a_neg ? ((~a_m + XLEN'(1)) & mask_n) : a_m;
    b_mag      = b_neg ? ((~b_m + XLEN'(1)) & mask_n) : b_m;
    dvd_raw    = (DW'(c_m) << n_q) | DW'(a_m);
    dvd_mag    = c_neg ? ((~dvd_raw + DW'(1)) & mask_2n) : dvd_raw;
    hi_mag     = XLEN'(dvd_mag >> n_q);
    lo_mag     = XLEN'(dvd_mag) & mask_n;
    prep_fault = is_div & ((b_mag == '0) | (hi_mag >= b_mag));
    shamt      = CW'(XLEN) - n_q;
  end

  logic [XLEN:0] trial;
  logic          trial_ge;
  assign trial    = {rem_q, mq_q[XLEN-1]};
  assign trial_ge = (trial >= {1'b0, opb_q});

  // Sign correction and overflow/flag evaluation for FIX.
  logic [DW-1:0]   prod;
  logic [XLEN-1:0] p_lo, p_hi, q_val, r_val, fix_lo, fix_hi;
  logic            q_ovf, fix_cf, fix_df;
  always_comb begin
    prod   = res_neg_q ? ((~acc_q + DW'(1)) & mask_2n) : acc_q;
    p_lo   = XLEN'(prod) & mask_n;
    p_hi   = XLEN'(prod >> n_q);
    q_val  = res_neg_q ? ((~mq_q + XLEN'(1)) & mask_n) : mq_q;
    r_val  = rem_neg_q ? ((~rem_q + XLEN'(1)) & mask_n) : rem_q;
    q_ovf  = is_sgn & (mq_q > (res_neg_q ? top_n : (top_n - XLEN'(1))));
    fix_lo = p_lo;
    fix_hi = p_hi;
    fix_df = 1'b0;
    fix_cf = is_sgn ? (p_hi != ((|(p_lo & top_n)) ? mask_n : '0)) : (p_hi != '0);
    if (is_div) begin
      fix_cf = 1'b0;
      fix_df = q_ovf;
      fix_lo = q_ovf ? '0 : q_val;
      fix_hi = q_ovf ? '0 : r_val;
    end
  end

  // State and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (in_valid) next_state = S_PREP;
      S_PREP: next_state = prep_fault ? S_DONE : S_ITER;
      S_ITER: if (cnt_q == '0) next_state = S_FIX;
      S_FIX:  next_state = S_DONE;
      S_DONE: if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (kill && (state != S_IDLE)) next_state = S_IDLE;
  end

  always_comb begin
    in_ready_d  = 1'b0;
    busy_d      = 1'b1;
    out_valid_d = 1'b0;
    case (next_state)
      S_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      S_DONE:  out_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_raw_q <= '0;
      opc_q     <= '0;
      opb_q     <= '0;
      mq_q      <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      cf_of     <= 1'b0;
      div_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q      <= op;
          n_q       <= eff_n(size);
          opa_q     <= opnd0_r;
          opb_raw_q <= opnd1_r;
          opc_q     <= opnd2_r;
          result_lo <= '0;
          result_hi <= '0;
          cf_of     <= 1'b0;
          div_fault <= 1'b0;
        end
        S_PREP: begin
          acc_q     <= '0;
          cnt_q     <= n_q - CW'(1);
          res_neg_q <= is_div ? (c_neg ^ b_neg) : (a_neg ^ b_neg);
          rem_neg_q <= c_neg;
          opb_q     <= is_div ? b_mag : a_mag;
          mq_q      <= (is_div ? lo_mag : b_mag) << shamt;
          rem_q     <= hi_mag;
          if (prep_fault) div_fault <= 1'b1;
        end
        S_ITER: begin
          cnt_q <= cnt_q - CW'(1);
          if (is_div) begin
            rem_q <= trial_ge ? XLEN'(trial - {1'b0, opb_q}) : XLEN'(trial);
            mq_q  <= {mq_q[XLEN-2:0], trial_ge};
          end else begin
            acc_q <= (acc_q << 1) + (mq_q[XLEN-1] ? DW'(opb_q) : '0);
            mq_q  <= mq_q << 1;
          end
        end
        S_FIX: begin
          result_lo <= fix_lo;
          result_hi <= fix_hi;
          cf_of     <= fix_cf;
          div_fault <= fix_df;
        end
        default: ;
      endcase
    end
  end
endmodule
